hmnoc_cluster_seq: RTL and testbench
====================================

// Module: hmnoc_cluster_seq
// PURPOSE
//  Sequencer for one HMNoC west cluster (GLB cluster + router cluster + PE cluster).
//  On 'go' it programs the three router modes, then streams weights and then iacts from the GLB
//  over the west router ports into the PE cluster. It then starts compute and drains the psums
//  into the psum GLB. Sits between the top-level controller/testbench and the cluster's control pins.
// PARAMETERS
//  DATA_WIDTH     16  datapath width (matches cluster)
//  ADDR_WIDTH     9   GLB address width
//  KERNEL_SIZE    3   filter side; NUM_WGHT = KERNEL_SIZE*KERNEL_SIZE words
//  ACT_SIZE       5   iact side; NUM_IACT = ACT_SIZE*ACT_SIZE words
//  X_DIM          3   PE columns = psum lanes per drain row
//  W_READ_ADDR    0   first weight GLB read address
//  A_READ_ADDR    0   first iact GLB read address
//  PSUM_LOAD_ADDR 0   first psum GLB write address
//  GLB_RD_LAT     1   GLB read latency, cycles (1..3)
// PORTS
//  clk             in  1            clock, rising edge
//  reset           in  1            asynchronous, active-low reset
//  go              in  1            1-cycle pulse, start a layer; ignored while busy
//  abort           in  1            synchronous abort to IDLE
//  busy            out 1            high in every state except IDLE/DONE
//  done            out 1            1-cycle pulse on DONE entry
//  router_mode_wght/iact/psum out 4 router mode codes
//  read_req_wght   out 1            GLB weight read strobe
//  r_addr_wght     out ADDR_WIDTH   GLB weight read address
//  read_req_iact   out 1            GLB iact read strobe
//  r_addr_iact     out ADDR_WIDTH   GLB iact read address
//  west_enable_i_wght / west_enable_i_iact  out 1  router west-input valid, aligned to GLB data
//  load_en_wght / load_en_act               out 1  PE cluster load enables
//  load_done       in  1            PE cluster load complete
//  start           out 1            1-cycle compute start pulse
//  compute_done    in  1            PE cluster compute complete (level or pulse)
//  west_enable_i_psum out 1         psum router west-input valid
//  psum_sel        out $clog2(X_DIM) pe_out lane the wrapper muxes onto the psum router
//  w_addr_psum     out ADDR_WIDTH   psum GLB write address
// BEHAVIOUR
//  Reset values:
//   - all strobes/enables/start/done/busy = 0
//   - addresses = base parameters; psum_sel = 0
//   - modes: wght and iact = ALL(0), psum = ALL(0)
//  States: IDLE -> CFG -> LD_W -> LD_A -> WAIT_LD -> RUN -> WAIT_C -> DRAIN -> DONE -> IDLE.
//  - IDLE: wait for go.
//  - CFG (1 cycle): drive modes. wght = WEST(3), iact = WEST(3), psum = EAST(4).
//  - LD_W: NUM_WGHT cycles of read_req_wght.
//    - r_addr_wght = W_READ_ADDR + i.
//    - west_enable_i_wght is read_req_wght delayed GLB_RD_LAT cycles (shift reg).
//    - load_en_wght is high from state entry until the last enable has issued.
//  - LD_A: same as LD_W on iact ports with NUM_IACT/A_READ_ADDR. Starts the cycle after the last LD_W
//    request (weight enable tail overlaps; no bubble required).
//  - WAIT_LD: hold until the shift regs are empty and load_done=1.
//  - RUN: start=1 for 1 cycle, then WAIT_C until compute_done=1.
//  - DRAIN: X_DIM cycles.
//    - psum_sel = 0..X_DIM-1, west_enable_i_psum = 1.
//    - w_addr_psum = PSUM_LOAD_ADDR + k.
//    - The address advances after each write and persists across layers until reset; it wraps
//      modulo 2^ADDR_WIDTH.
//  - DONE: done=1, busy=0, modes are kept; next cycle IDLE.
//  Counters are wide enough for NUM_IACT and never exceed terminal count.
//  Read addresses wrap modulo 2^ADDR_WIDTH.
//  Boundary cases:
//   - go while busy: ignored.
//   - go and abort in the same cycle: abort wins.
//   - abort (any state): next cycle is IDLE with reset values, except w_addr_psum, which is kept.
//     Delay shift regs are flushed, so no stale enable appears.
//   - load_done/compute_done outside their wait states: ignored.
//   - Asynchronous reset mid-stream: immediate reset values.
// CONFIGURATION
//  HMNOC_SEQ_PERF_EN defined:
//   - Adds output cycle_count[31:0]: cycles from CFG entry to DONE inclusive.
//   - Adds output stall_count[31:0]: cycles spent in WAIT_LD+WAIT_C.
//   - Both clear on go and hold their value after DONE.
//  HMNOC_SEQ_PERF_EN undefined: neither port nor counter exists.
// STRUCTURE
//  Shared package hmnoc_pkg:
//   - router_dir_e enum (ALL=0,NORTH=1,SOUTH=2,WEST=3,EAST=4,EASTNORTH=5,EASTSOUTH=6,EASTWEST=7,
//     WESTNORTH=8,WESTSOUTH=9,WESTEAST=10)
//   - seq_state_e
//  One sub-module: hmnoc_glb_rd_stream. It contains the addr counter, the req strobe, the
//  GLB_RD_LAT delay line and a last flag. It is instantiated twice (wght, iact).
// TESTING
//  1. Defaults; go at cycle 10; load_done 2 cycles after the last iact enable; compute_done 20
//     cycles after start -> 9 wght reqs at addr 0..8 with enables 1 cycle later; then 25 iact reqs
//     at addr 0..24; one start pulse; 3 psum writes, psum_sel 0,1,2 at addr 0,1,2; one done pulse.
//  2. A second go after DONE -> psum writes land at addr 3,4,5; read addresses restart at base.
//  3. abort during LD_A on the 10th request -> next cycle IDLE; no further read_req or enable; a
//     new go completes normally.
//  4. GLB_RD_LAT=3, W_READ_ADDR=510 -> wght addrs 510,511,0..6 (wrap); each enable trails its
//     req by exactly 3 cycles.
//  5. go pulsed during WAIT_C, and compute_done pulsed during LD_W -> neither is acted on;
//     sequence waits for the real compute_done.
//  6. HMNOC_SEQ_PERF_EN defined, scenario 1 -> stall_count = 2+1+20, matching the waveform;
//     cycle_count equals the CFG..DONE span.

Source files
------------

// File: rtl/hmnoc_pkg.sv
// Shared types for the HMNoC west-cluster sequencer: router direction codes and sequencer states.
package hmnoc_pkg;

  typedef enum logic [3:0] {
    ALL       = 4'd0,
    NORTH     = 4'd1,
    SOUTH     = 4'd2,
    WEST      = 4'd3,
    EAST      = 4'd4,
    EASTNORTH = 4'd5,
    EASTSOUTH = 4'd6,
    EASTWEST  = 4'd7,
    WESTNORTH = 4'd8,
    WESTSOUTH = 4'd9,
    WESTEAST  = 4'd10
  } router_dir_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CFG     = 4'd1,
    S_LD_W    = 4'd2,
    S_LD_A    = 4'd3,
    S_WAIT_LD = 4'd4,
    S_RUN     = 4'd5,
    S_WAIT_C  = 4'd6,
    S_DRAIN   = 4'd7,
    S_DONE    = 4'd8
  } seq_state_e;

  function automatic logic is_busy_state(input seq_state_e s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/hmnoc_glb_rd_stream.sv
// One GLB read stream: address counter, read strobe, read-latency delay line and load-enable window.
module hmnoc_glb_rd_stream
  import hmnoc_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 5,
  parameter int NUM_WORDS  = 9,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  start,
  output logic                  read_req,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  west_en,
  output logic                  load_en,
  output logic                  last,
  output logic                  drained
);

  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RD_LAT-1:0]     UP_MASK  = {RD_LAT{1'b1}} >> 1;

  logic                  req_q, req_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0]     dly_q, dly_d;
  logic                  load_en_q, load_en_d;

  assign last     = req_q && (cnt_q == LAST_CNT);
  assign drained  = !req_q && (dly_q == '0);
  assign read_req = req_q;
  assign r_addr   = addr_q;
  assign west_en  = dly_q[RD_LAT-1];
  assign load_en  = load_en_q;

  always_comb begin
    req_d     = req_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    load_en_d = load_en_q;
    dly_d[0]  = req_q;
    for (int i = 1; i < RD_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    if (clr) begin
      req_d     = 1'b0;
      cnt_d     = '0;
      addr_d    = BASE;
      load_en_d = 1'b0;
      dly_d     = '0;
    end else if (start) begin
      req_d     = 1'b1;
      cnt_d     = '0;
      addr_d    = BASE;
      load_en_d = 1'b1;
    end else begin
      if (last) begin
        req_d = 1'b0;
      end else if (req_q) begin
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        addr_d = addr_q + ADDR_WIDTH'(1);
      end else begin
        req_d = 1'b0;
      end
      // Window closes once the final enable is on the output with nothing behind it.
      if (dly_q[RD_LAT-1] && !req_q && ((dly_q & UP_MASK) == '0)) begin
        load_en_d = 1'b0;
      end else begin
        load_en_d = load_en_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= BASE;
      dly_q     <= '0;
      load_en_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dly_q     <= dly_d;
      load_en_q <= load_en_d;
    end
  end

endmodule

// File: rtl/hmnoc_cluster_seq.sv
// HMNoC west-cluster sequencer: configure routers, stream weights/iacts, compute, drain psums.
// Optional HMNOC_SEQ_PERF_EN adds cycle_count/stall_count performance counters.
module hmnoc_cluster_seq
  import hmnoc_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 9,
  parameter int KERNEL_SIZE    = 3,
  parameter int ACT_SIZE       = 5,
  parameter int X_DIM          = 3,
  parameter int W_READ_ADDR    = 0,
  parameter int A_READ_ADDR    = 0,
  parameter int PSUM_LOAD_ADDR = 0,
  parameter int GLB_RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            router_mode_wght,
  output logic [3:0]            router_mode_iact,
  output logic [3:0]            router_mode_psum,
  output logic                  read_req_wght,
  output logic [ADDR_WIDTH-1:0] r_addr_wght,
  output logic                  read_req_iact,
  output logic [ADDR_WIDTH-1:0] r_addr_iact,
  output logic                  west_enable_i_wght,
  output logic                  west_enable_i_iact,
  output logic                  load_en_wght,
  output logic                  load_en_act,
  input  logic                  load_done,
  output logic                  start,
  input  logic                  compute_done,
  output logic                  west_enable_i_psum,
  output logic [((X_DIM > 1) ? $clog2(X_DIM) : 1)-1:0] psum_sel,
  output logic [ADDR_WIDTH-1:0] w_addr_psum
`ifdef HMNOC_SEQ_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int NUM_WGHT = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NUM_IACT = ACT_SIZE * ACT_SIZE;
  localparam int CNT_W    = $clog2(((NUM_IACT > NUM_WGHT) ? NUM_IACT : NUM_WGHT) + 1);
  localparam int SEL_W    = (X_DIM > 1) ? $clog2(X_DIM) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(X_DIM - 1);

  // Datapath width belongs to the cluster; the sequencer never touches data words.
  if (DATA_WIDTH <= 0) begin : g_bad_data_width
  end

  seq_state_e            state_q, state_d;
  router_dir_e           mode_w_q, mode_w_d, mode_a_q, mode_a_d, mode_p_q, mode_p_d;
  logic                  busy_q, busy_d, done_q, done_d, start_q, start_d;
  logic                  wep_q, wep_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  w_start_s, a_start_s, w_last_s, a_last_s, w_drained_s, a_drained_s;
  logic                  go_accept_s;

  assign go_accept_s = go && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_start_s   = (state_q == S_CFG);
  assign a_start_s   = (state_q == S_LD_W) && w_last_s;

  hmnoc_glb_rd_stream #(
    .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_W), .NUM_WORDS(NUM_WGHT),
    .BASE_ADDR(W_READ_ADDR), .RD_LAT(GLB_RD_LAT)
  ) u_wght (
    .clk(clk), .reset(reset), .clr(abort), .start(w_start_s),
    .read_req(read_req_wght), .r_addr(r_addr_wght), .west_en(west_enable_i_wght),
    .load_en(load_en_wght), .last(w_last_s), .drained(w_drained_s)
  );

  hmnoc_glb_rd_stream #(
    .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_W), .NUM_WORDS(NUM_IACT),
    .BASE_ADDR(A_READ_ADDR), .RD_LAT(GLB_RD_LAT)
  ) u_iact (
    .clk(clk), .reset(reset), .clr(abort), .start(a_start_s),
    .read_req(read_req_iact), .r_addr(r_addr_iact), .west_en(west_enable_i_iact),
    .load_en(load_en_act), .last(a_last_s), .drained(a_drained_s)
  );

  always_comb begin
    state_d  = state_q;
    mode_w_d = mode_w_q;
    mode_a_d = mode_a_q;
    mode_p_d = mode_p_q;
    start_d  = 1'b0;
    wep_d    = 1'b0;
    sel_d    = sel_q;
    paddr_d  = paddr_q;
    // Abort returns to reset values but keeps the psum write pointer.
    if (abort) begin
      state_d  = S_IDLE;
      mode_w_d = ALL;
      mode_a_d = ALL;
      mode_p_d = ALL;
      sel_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go_accept_s) begin
            state_d  = S_CFG;
            mode_w_d = WEST;
            mode_a_d = WEST;
            mode_p_d = EAST;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CFG:     state_d = S_LD_W;
        S_LD_W:    state_d = w_last_s ? S_LD_A : S_LD_W;
        S_LD_A:    state_d = a_last_s ? S_WAIT_LD : S_LD_A;
        S_WAIT_LD: begin
          if (w_drained_s && a_drained_s && load_done) begin
            state_d = S_RUN;
            start_d = 1'b1;
          end else begin
            state_d = S_WAIT_LD;
          end
        end
        S_RUN:     state_d = S_WAIT_C;
        S_WAIT_C: begin
          if (compute_done) begin
            state_d = S_DRAIN;
            wep_d   = 1'b1;
            sel_d   = '0;
          end else begin
            state_d = S_WAIT_C;
          end
        end
        S_DRAIN: begin
          paddr_d = paddr_q + ADDR_WIDTH'(1);
          if (sel_q == LAST_SEL) begin
            state_d = S_DONE;
            sel_d   = '0;
          end else begin
            sel_d = sel_q + SEL_W'(1);
            wep_d = 1'b1;
          end
        end
        default:   state_d = S_IDLE;
      endcase
    end
    busy_d = is_busy_state(state_d);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_w_q <= ALL;
      mode_a_q <= ALL;
      mode_p_q <= ALL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      wep_q    <= 1'b0;
      sel_q    <= '0;
      paddr_q  <= ADDR_WIDTH'(PSUM_LOAD_ADDR);
    end else begin
      state_q  <= state_d;
      mode_w_q <= mode_w_d;
      mode_a_q <= mode_a_d;
      mode_p_q <= mode_p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      wep_q    <= wep_d;
      sel_q    <= sel_d;
      paddr_q  <= paddr_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign start              = start_q;
  assign router_mode_wght   = mode_w_q;
  assign router_mode_iact   = mode_a_q;
  assign router_mode_psum   = mode_p_q;
  assign west_enable_i_psum = wep_q;
  assign psum_sel           = sel_q;
  assign w_addr_psum        = paddr_q;

`ifdef HMNOC_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d;

  // Counting covers CFG through DONE; values freeze in IDLE until the next accepted go.
  always_comb begin
    if (go_accept_s) begin
      cyc_d   = 32'd0;
      stall_d = 32'd0;
    end else if (state_q != S_IDLE) begin
      cyc_d   = cyc_q + 32'd1;
      stall_d = ((state_q == S_WAIT_LD) || (state_q == S_WAIT_C)) ? stall_q + 32'd1 : stall_q;
    end else begin
      cyc_d   = cyc_q;
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q   <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign cycle_count = cyc_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_hmnoc_cluster_seq.sv
// Scoreboard bench for hmnoc_cluster_seq: expected GLB/psum traffic is queued at go, checked as it appears.
module tb_hmnoc_cluster_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, go, abort, load_done, compute_done, go2;
  logic       busy, done, rq_w, rq_a, we_w, we_a, ld_w, ld_a, strt, wep;
  logic [3:0] mw, mi, mp;
  logic [8:0] ra_w, ra_a, wa_p;
  logic [1:0] psel;
  logic       busy2, done2, rq_w2, rq_a2, we_w2, we_a2, ld_w2, ld_a2, strt2, wep2;
  logic [3:0] mw2, mi2, mp2;
  logic [8:0] ra_w2, ra_a2, wa_p2;
  logic [1:0] psel2;
`ifdef HMNOC_SEQ_PERF_EN
  logic [31:0] cyc_cnt, stall_cnt, cyc_cnt2, stall_cnt2;
`endif

  hmnoc_cluster_seq u_dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort), .busy(busy), .done(done),
    .router_mode_wght(mw), .router_mode_iact(mi), .router_mode_psum(mp),
    .read_req_wght(rq_w), .r_addr_wght(ra_w), .read_req_iact(rq_a), .r_addr_iact(ra_a),
    .west_enable_i_wght(we_w), .west_enable_i_iact(we_a),
    .load_en_wght(ld_w), .load_en_act(ld_a), .load_done(load_done), .start(strt),
    .compute_done(compute_done), .west_enable_i_psum(wep), .psum_sel(psel), .w_addr_psum(wa_p)
`ifdef HMNOC_SEQ_PERF_EN
    , .cycle_count(cyc_cnt), .stall_count(stall_cnt)
`endif
  );

  hmnoc_cluster_seq #(.GLB_RD_LAT(3), .W_READ_ADDR(510)) u_dut_lat3 (
    .clk(clk), .reset(reset), .go(go2), .abort(1'b0), .busy(busy2), .done(done2),
    .router_mode_wght(mw2), .router_mode_iact(mi2), .router_mode_psum(mp2),
    .read_req_wght(rq_w2), .r_addr_wght(ra_w2), .read_req_iact(rq_a2), .r_addr_iact(ra_a2),
    .west_enable_i_wght(we_w2), .west_enable_i_iact(we_a2),
    .load_en_wght(ld_w2), .load_en_act(ld_a2), .load_done(1'b1), .start(strt2),
    .compute_done(1'b1), .west_enable_i_psum(wep2), .psum_sel(psel2), .w_addr_psum(wa_p2)
`ifdef HMNOC_SEQ_PERF_EN
    , .cycle_count(cyc_cnt2), .stall_count(stall_cnt2)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_w[$], exp_a[$], exp_p[$], due_w[$], due_a[$], exp_w2[$], due_w2[$];
  int w_reqs, a_reqs, w2_reqs, starts, dones, done2_cnt, start_cyc, ld_due, cd_due, first_psum_cyc;
  int psum_next = 0;
  bit done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic monitor();
    if (rq_w) begin
      w_reqs++;
      check("wght_req_expected", 32'(exp_w.size() != 0), 1);
      if (exp_w.size() != 0) check("wght_addr", 32'(ra_w), exp_w.pop_front());
      due_w.push_back(cyc + 1);
    end
    if (we_w) begin
      check("wght_en_expected", 32'(due_w.size() != 0), 1);
      if (due_w.size() != 0) check("wght_en_cycle", cyc, due_w.pop_front());
      check("wght_load_en", 32'(ld_w), 1);
    end
    if (rq_a) begin
      a_reqs++;
      check("iact_req_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) check("iact_addr", 32'(ra_a), exp_a.pop_front());
      due_a.push_back(cyc + 1);
    end
    if (we_a) begin
      check("iact_en_expected", 32'(due_a.size() != 0), 1);
      if (due_a.size() != 0) check("iact_en_cycle", cyc, due_a.pop_front());
      check("iact_load_en", 32'(ld_a), 1);
      if (exp_a.size() == 0 && due_a.size() == 0 && a_reqs == 25) ld_due = cyc + 2;
    end
    if (wep) begin
      if (first_psum_cyc < 0) first_psum_cyc = cyc;
      check("psum_expected", 32'(exp_p.size() != 0), 1);
      if (exp_p.size() != 0) check("psum_sel_addr", 32'({psel, wa_p}), exp_p.pop_front());
    end
    if (strt) begin
      starts++;
      start_cyc = cyc;
      cd_due = cyc + 20;
    end
    if (done) begin
      dones++;
      done_seen = 1'b1;
      check("done_busy_low", 32'(busy), 0);
      check("done_modes_kept", 32'({mw, mi, mp}), 32'h334);
    end
    if (rq_w2) begin
      w2_reqs++;
      check("lat3_req_expected", 32'(exp_w2.size() != 0), 1);
      if (exp_w2.size() != 0) check("lat3_wght_addr", 32'(ra_w2), exp_w2.pop_front());
      due_w2.push_back(cyc + 3);
    end
    if (we_w2) begin
      check("lat3_en_expected", 32'(due_w2.size() != 0), 1);
      if (due_w2.size() != 0) check("lat3_en_cycle", cyc, due_w2.pop_front());
    end
    if (done2) done2_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    go = 1'b0; go2 = 1'b0; abort = 1'b0; load_done = 1'b0; compute_done = 1'b0;
    monitor();
  endtask

  task automatic run_layer(input bit pert, input int abort_at, input bit perf_chk);
    w_reqs = 0; a_reqs = 0; starts = 0; dones = 0; done_seen = 1'b0;
    ld_due = -1; cd_due = -1; start_cyc = -1; first_psum_cyc = -1;
    for (int i = 0; i < 9; i++) exp_w.push_back(i);
    for (int i = 0; i < 25; i++) exp_a.push_back(i);
    for (int k = 0; k < 3; k++) exp_p.push_back(k * 512 + ((psum_next + k) % 512));
    go = 1'b1;
    tick();
    check("cfg_busy", 32'(busy), 1);
    check("cfg_modes", 32'({mw, mi, mp}), 32'h334);
    for (int n = 0; n < 200 && !done_seen; n++) begin
      if (abort_at > 0 && a_reqs == abort_at) begin
        abort = 1'b1;
        go = 1'b1;
        exp_a.delete(); due_a.delete(); exp_p.delete();
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_modes", 32'({mw, mi, mp}), 0);
        check("abort_iact_addr", 32'(ra_a), 0);
        check("abort_load_en", 32'({ld_w, ld_a}), 0);
        check("abort_psum_addr_kept", 32'(wa_p), psum_next);
        for (int m = 0; m < 12; m++) tick();
        check("abort_no_more_req", a_reqs, abort_at);
        return;
      end
      if (cyc == ld_due) load_done = 1'b1;
      if (cyc == cd_due) compute_done = 1'b1;
      if (pert && w_reqs == 1) compute_done = 1'b1;
      if (pert && start_cyc >= 0 && cyc == start_cyc + 5) go = 1'b1;
      tick();
    end
    check("layer_done", 32'(done_seen), 1);
    tick();
    tick();
    check("start_pulses", starts, 1);
    check("done_pulses", dones, 1);
    check("wght_reqs", w_reqs, 9);
    check("iact_reqs", a_reqs, 25);
    check("drain_timing", first_psum_cyc, start_cyc + 21);
    check("psum_left", exp_p.size(), 0);
    check("idle_busy", 32'(busy), 0);
    psum_next = (psum_next + 3) % 512;
`ifdef HMNOC_SEQ_PERF_EN
    if (perf_chk) begin
      check("perf_stall_count", stall_cnt, 23);
      check("perf_cycle_count", cyc_cnt, 63);
    end
`endif
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; go2 = 1'b0; abort = 1'b0; load_done = 1'b0; compute_done = 1'b0;
    w2_reqs = 0; done2_cnt = 0;
    tick();
    tick();
    check("rst_busy_done_start", 32'({busy, done, strt}), 0);
    check("rst_modes", 32'({mw, mi, mp}), 0);
    check("rst_strobes", 32'({rq_w, rq_a, we_w, we_a, ld_w, ld_a, wep}), 0);
    check("rst_addrs", 32'({ra_w, ra_a, wa_p}), 0);
    check("rst_psum_sel", 32'(psel), 0);
    reset = 1'b1;
    tick();
    go = 1'b1;
    abort = 1'b1;
    tick();
    check("go_abort_same_cycle", 32'(busy), 0);
    while (cyc < 9) tick();

    run_layer(1'b0, 0, 1'b1);
    run_layer(1'b0, 0, 1'b0);
    run_layer(1'b0, 10, 1'b0);
    run_layer(1'b0, 0, 1'b0);
    run_layer(1'b1, 0, 1'b0);

    exp_w2.push_back(510);
    exp_w2.push_back(511);
    for (int i = 0; i < 7; i++) exp_w2.push_back(i);
    go2 = 1'b1;
    for (int n = 0; n < 100 && done2_cnt == 0; n++) tick();
    check("lat3_reqs", w2_reqs, 9);
    check("lat3_en_left", due_w2.size(), 0);
    check("lat3_done", done2_cnt, 1);

    for (int i = 0; i < 9; i++) exp_w.push_back(i);
    go = 1'b1;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_req", 32'({rq_w, we_w, ld_w}), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_wr_addr", 32'(wa_p), 0);
    check("async_rst_mode", 32'(mw), 0);
    exp_w.delete(); due_w.delete();
    tick();
    reset = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
